sample_msg_demux: RTL and testbench
===================================

// Module: sample_msg_demux
// PURPOSE
//  Parametrised successor to the sample/message splitter. Splits a mixed input stream
//  (samples, message headers, message contents) into one sample stream and N_DEST message streams.
//  The destination is selected by an address field in each header.
//  Sits between the front-end word stream and per-block message consumers; unroutable
//  packets are discarded and reported.
// PARAMETERS
//  WIDTH            32  word width; bit WIDTH-1 = header flag
//  MSG_LENGTH_WIDTH 8   header length field, bits [WIDTH-2 -: MSG_LENGTH_WIDTH]
//  ADDR_WIDTH       4   header dest field, bits [WIDTH-2-MSG_LENGTH_WIDTH -: ADDR_WIDTH]
//  N_DEST           3   number of message outputs, 1..2**ADDR_WIDTH
// PORTS
//  clk          in   1             clock; all logic on rising edge
//  rst          in   1             synchronous, active-high reset
//  in_data      in   WIDTH         input word
//  in_nd        in   1             in_data valid this cycle
//  error_clr    in   1             clears sticky error bits
//  out_samples  out  WIDTH         sample word
//  out_samples_nd out 1            sample valid
//  out_msg      out  WIDTH         message word (shared by all destinations)
//  out_msg_nd   out  N_DEST        one-hot message valid; bit d = destination d
//  out_msg_last out  1             marks final word of a packet (header when length 0)
//  error        out  2             sticky: [0] header inside packet, [1] dest >= N_DEST
// BEHAVIOUR
//  - Reset: all *_nd=0, out_msg_last=0, error=0, state=IDLE, pos=0, len=0, dest=0.
//    out_samples and out_msg data = 0.
//  - Latency: exactly 1 cycle, in_nd -> output valid. No backpressure.
//    in_nd=0 -> all *_nd=0 next cycle; data outputs hold.
//  - States: IDLE (samples), MSG (routing contents), DROP (discarding contents).
//  - Header (in_nd & in_data[WIDTH-1]), any state: latch len, dest; pos<=1.
//    - dest<N_DEST:
//      - emit header on out_msg, out_msg_nd[dest]=1.
//      - len==0 -> out_msg_last=1, stay/go IDLE; else -> MSG.
//    - dest>=N_DEST: nothing emitted, error[1]<=1; len==0 -> IDLE, else -> DROP.
//    - Header while in MSG/DROP: error[0]<=1; old packet aborted, no last marker on it;
//      new header processed normally.
//  - Non-header word:
//    - IDLE -> out_samples, out_samples_nd=1.
//    - MSG -> out_msg, out_msg_nd[dest]=1.
//    - DROP -> discarded.
//    - MSG/DROP: pos==len -> out_msg_last=1 (MSG only), pos<=0, -> IDLE; else pos<=pos+1.
//  - Max length 2**MSG_LENGTH_WIDTH-1; pos is MSG_LENGTH_WIDTH bits and never wraps
//    (terminates at len).
//  - Never more than one *_nd output high in a cycle.
//  - error_clr clears both bits; if set and clr coincide, set wins.
//  - rst mid-packet: packet abandoned; next non-header word is a sample.
// CONFIGURATION
//  SAMPLE_MSG_DEMUX_ERRCNT_EN defined:
//    - adds port error_count out 16.
//    - increments once per error event (both events on the same word count as 2),
//      saturating at 16'hFFFF.
//    - cleared by rst or error_clr; clr with coincident events -> count = number of events.
//  Undefined: port absent; behaviour otherwise identical.
// TESTING (WIDTH=32, MSG_LENGTH_WIDTH=8, ADDR_WIDTH=4, N_DEST=3)
//  1 Samples 0x1,0x2 then hdr 0x8108_0000 (len2,dest1), 0xA, 0xB, sample 0x3
//    -> samples 1,2; out_msg_nd=3'b010 x3; last on 0xB; 0x3 on samples.
//  2 hdr 0x8010_0000 (len0,dest2) -> one word, out_msg_nd=3'b100, out_msg_last=1;
//    next 0x5 is sample.
//  3 hdr 0x8118_0000 (len2,dest3), 0xA, 0xB, 0x7 -> no msg valids; error=2'b10;
//    0x7 on samples.
//  4 hdr 0x8180_0000 (len3,dest0), 0xA, then hdr 0x8088_0000 (len1,dest1), 0xC
//    -> error=2'b01; 0xC on dest1 with last.
//  5 in_nd gaps inside a packet; rst asserted after first content word
//    -> outputs zero next cycle; next content word 0xD is a sample.
//  6 ERRCNT_EN: 3 bad-dest headers, error_clr with a 4th -> count 3 then 1; error[1]=1.

Source files
------------

// File: rtl/sample_msg_demux_if.sv
// Bundle for the sample/message demultiplexer: the input word stream and the split outputs.
// error_count is present only when SAMPLE_MSG_DEMUX_ERRCNT_EN is defined.
interface sample_msg_demux_if #(
    parameter int WIDTH  = 32,
    parameter int N_DEST = 3
);
    logic [WIDTH-1:0]  in_data;
    logic              in_nd;
    logic              error_clr;
    logic [WIDTH-1:0]  out_samples;
    logic              out_samples_nd;
    logic [WIDTH-1:0]  out_msg;
    logic [N_DEST-1:0] out_msg_nd;
    logic              out_msg_last;
    logic [1:0]        error;
`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
    logic [15:0]       error_count;

    modport master (
        output in_data, in_nd, error_clr,
        input  out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_last, error, error_count
    );
    modport slave (
        input  in_data, in_nd, error_clr,
        output out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_last, error, error_count
    );
`else
    modport master (
        output in_data, in_nd, error_clr,
        input  out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_last, error
    );
    modport slave (
        input  in_data, in_nd, error_clr,
        output out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_last, error
    );
`endif
endinterface

// File: rtl/sample_msg_demux.sv
// Splits a mixed word stream into a sample stream and N_DEST addressed message streams.
// Optional saturating error event counter enabled by SAMPLE_MSG_DEMUX_ERRCNT_EN.
module sample_msg_demux #(
    parameter int WIDTH            = 32,
    parameter int MSG_LENGTH_WIDTH = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int N_DEST           = 3
) (
    input  logic           clk,
    input  logic           rst,
    sample_msg_demux_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MSG, DROP} state_t;

    state_t                      state_reg, state_next;
    logic [MSG_LENGTH_WIDTH-1:0] pos_reg, pos_next;
    logic [MSG_LENGTH_WIDTH-1:0] len_reg, len_next;
    logic [ADDR_WIDTH-1:0]       dest_reg, dest_next;

    logic [WIDTH-1:0]  out_samples_reg, out_samples_next;
    logic              out_samples_nd_reg, out_samples_nd_next;
    logic [WIDTH-1:0]  out_msg_reg, out_msg_next;
    logic [N_DEST-1:0] out_msg_nd_reg, out_msg_nd_next;
    logic              out_msg_last_reg, out_msg_last_next;
    logic [1:0]        error_reg, error_next;

    logic                        is_hdr;
    logic [MSG_LENGTH_WIDTH-1:0] hdr_len;
    logic [ADDR_WIDTH-1:0]       hdr_dest;
    logic                        dest_ok;
    logic                        pos_at_end;
    logic                        ev_abort, ev_bad_dest;
    logic [N_DEST-1:0]           hdr_onehot, dest_onehot;

    assign is_hdr      = bus.in_nd & bus.in_data[WIDTH-1];
    assign hdr_len     = bus.in_data[WIDTH-2 -: MSG_LENGTH_WIDTH];
    assign hdr_dest    = bus.in_data[WIDTH-2-MSG_LENGTH_WIDTH -: ADDR_WIDTH];
    assign dest_ok     = {1'b0, hdr_dest} < (ADDR_WIDTH+1)'(N_DEST);
    assign pos_at_end  = (pos_reg == len_reg);
    assign ev_abort    = is_hdr & (state_reg != IDLE);
    assign ev_bad_dest = is_hdr & ~dest_ok;

    // One-hot destination decodes keep the valid vector indexing width-clean.
    generate
        for (genvar gi = 0; gi < N_DEST; gi++) begin : g_onehot
            assign hdr_onehot[gi]  = (hdr_dest == ADDR_WIDTH'(gi));
            assign dest_onehot[gi] = (dest_reg == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            pos_reg            <= '0;
            len_reg            <= '0;
            dest_reg           <= '0;
            out_samples_reg    <= '0;
            out_samples_nd_reg <= 1'b0;
            out_msg_reg        <= '0;
            out_msg_nd_reg     <= '0;
            out_msg_last_reg   <= 1'b0;
            error_reg          <= 2'b00;
        end else begin
            state_reg          <= state_next;
            pos_reg            <= pos_next;
            len_reg            <= len_next;
            dest_reg           <= dest_next;
            out_samples_reg    <= out_samples_next;
            out_samples_nd_reg <= out_samples_nd_next;
            out_msg_reg        <= out_msg_next;
            out_msg_nd_reg     <= out_msg_nd_next;
            out_msg_last_reg   <= out_msg_last_next;
            error_reg          <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        len_next   = len_reg;
        dest_next  = dest_reg;
        if (is_hdr) begin
            len_next  = hdr_len;
            dest_next = hdr_dest;
            pos_next  = 1;
            if (hdr_len == '0)
                state_next = IDLE;
            else
                state_next = dest_ok ? MSG : DROP;
        end else if (bus.in_nd && state_reg != IDLE) begin
            if (pos_at_end) begin
                pos_next   = '0;
                state_next = IDLE;
            end else begin
                pos_next = pos_reg + 1'b1;
            end
        end
    end

    always_comb begin
        out_samples_next    = out_samples_reg;
        out_samples_nd_next = 1'b0;
        out_msg_next        = out_msg_reg;
        out_msg_nd_next     = '0;
        out_msg_last_next   = 1'b0;
        // Clear first so a coincident event re-sets its bit.
        error_next          = bus.error_clr ? 2'b00 : error_reg;
        if (ev_abort)
            error_next[0] = 1'b1;
        if (ev_bad_dest)
            error_next[1] = 1'b1;
        if (is_hdr) begin
            if (dest_ok) begin
                out_msg_next      = bus.in_data;
                out_msg_nd_next   = hdr_onehot;
                out_msg_last_next = (hdr_len == '0);
            end
        end else if (bus.in_nd) begin
            case (state_reg)
                IDLE: begin
                    out_samples_next    = bus.in_data;
                    out_samples_nd_next = 1'b1;
                end
                MSG: begin
                    out_msg_next      = bus.in_data;
                    out_msg_nd_next   = dest_onehot;
                    out_msg_last_next = pos_at_end;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_samples    = out_samples_reg;
    assign bus.out_samples_nd = out_samples_nd_reg;
    assign bus.out_msg        = out_msg_reg;
    assign bus.out_msg_nd     = out_msg_nd_reg;
    assign bus.out_msg_last   = out_msg_last_reg;
    assign bus.error          = error_reg;

`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
    logic [15:0] error_count_reg, error_count_next;
    logic [16:0] count_sum;

    always_comb begin
        count_sum = {1'b0, (bus.error_clr ? 16'd0 : error_count_reg)}
                    + 17'(ev_abort) + 17'(ev_bad_dest);
        error_count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            error_count_reg <= '0;
        else
            error_count_reg <= error_count_next;
    end

    assign bus.error_count = error_count_reg;
`endif
endmodule

// File: tb/tb_sample_msg_demux.sv
// Directed self-checking bench for sample_msg_demux (WIDTH=32, LEN=8, ADDR=4, N_DEST=3).
module tb_sample_msg_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sample_msg_demux_if #(.WIDTH(32), .N_DEST(3)) bus ();

    sample_msg_demux #(
        .WIDTH(32), .MSG_LENGTH_WIDTH(8), .ADDR_WIDTH(4), .N_DEST(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {out_samples_nd, out_msg_nd[2:0], out_msg_last}
    logic [4:0] flags;
    assign flags = {bus.out_samples_nd, bus.out_msg_nd, bus.out_msg_last};

    // Apply one input word at the falling edge; outputs are valid 1ns after the next rising edge.
    task automatic step(input logic [31:0] d, input logic nd, input logic clr, input logic r);
        @(negedge clk);
        bus.in_data   = d;
        bus.in_nd     = nd;
        bus.error_clr = clr;
        rst           = r;
        @(posedge clk);
        #1;
        $display("t=%0t in=%h nd=%b clr=%b rst=%b -> flags=%b smp=%h msg=%h err=%b",
                 $time, d, nd, clr, r, flags, bus.out_samples, bus.out_msg, bus.error);
    endtask

    task automatic test_reset();
        bus.in_data = '0; bus.in_nd = 1'b0; bus.error_clr = 1'b0;
        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h8010_0000, 1'b1, 1'b0, 1'b1);
        if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b0); end checks++;
        if (bus.out_samples !== 32'h0 || bus.out_msg !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.out_samples, bus.out_msg); end checks++;
        if (bus.error !== 2'b00) begin errors++; $display("FAIL reset_error got=%b exp=00", bus.error); end checks++;
    endtask

    task automatic test_routing();
        step(32'h1, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h1) begin errors++; $display("FAIL t1_s1 got=%b/%h exp=10000/1", flags, bus.out_samples); end checks++;
        step(32'h2, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h2) begin errors++; $display("FAIL t1_s2 got=%b/%h exp=10000/2", flags, bus.out_samples); end checks++;
        step(32'h8108_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00100 || bus.out_msg !== 32'h8108_0000) begin errors++; $display("FAIL t1_hdr got=%b/%h exp=00100/81080000", flags, bus.out_msg); end checks++;
        step(32'hA, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00100 || bus.out_msg !== 32'hA) begin errors++; $display("FAIL t1_A got=%b/%h exp=00100/a", flags, bus.out_msg); end checks++;
        step(32'hB, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00101 || bus.out_msg !== 32'hB) begin errors++; $display("FAIL t1_B_last got=%b/%h exp=00101/b", flags, bus.out_msg); end checks++;
        step(32'h3, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h3) begin errors++; $display("FAIL t1_s3 got=%b/%h exp=10000/3", flags, bus.out_samples); end checks++;
    endtask

    task automatic test_zero_length();
        step(32'h8010_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b01001 || bus.out_msg !== 32'h8010_0000) begin errors++; $display("FAIL t2_hdr got=%b/%h exp=01001/80100000", flags, bus.out_msg); end checks++;
        step(32'h5, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h5) begin errors++; $display("FAIL t2_s5 got=%b/%h exp=10000/5", flags, bus.out_samples); end checks++;
    endtask

    task automatic test_bad_dest();
        step(32'h8118_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00000 || bus.error !== 2'b10) begin errors++; $display("FAIL t3_hdr got=%b/%b exp=00000/10", flags, bus.error); end checks++;
        step(32'hA, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00000) begin errors++; $display("FAIL t3_dropA got=%b exp=00000", flags); end checks++;
        step(32'hB, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00000 || bus.out_msg !== 32'h8010_0000) begin errors++; $display("FAIL t3_dropB got=%b/%h exp=00000/80100000", flags, bus.out_msg); end checks++;
        step(32'h7, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h7 || bus.error !== 2'b10) begin errors++; $display("FAIL t3_s7 got=%b/%h/%b exp=10000/7/10", flags, bus.out_samples, bus.error); end checks++;
    endtask

    task automatic test_abort();
        step(32'h0, 1'b0, 1'b1, 1'b0);
        if (bus.error !== 2'b00) begin errors++; $display("FAIL t4_clr got=%b exp=00", bus.error); end checks++;
        step(32'h8180_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00010) begin errors++; $display("FAIL t4_hdr0 got=%b exp=00010", flags); end checks++;
        step(32'hA, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00010 || bus.out_msg !== 32'hA) begin errors++; $display("FAIL t4_A got=%b/%h exp=00010/a", flags, bus.out_msg); end checks++;
        step(32'h8088_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00100 || bus.error !== 2'b01) begin errors++; $display("FAIL t4_hdr1 got=%b/%b exp=00100/01", flags, bus.error); end checks++;
        step(32'hC, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00101 || bus.out_msg !== 32'hC) begin errors++; $display("FAIL t4_C got=%b/%h exp=00101/c", flags, bus.out_msg); end checks++;
    endtask

    task automatic test_gap_and_reset();
        step(32'h8180_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00010) begin errors++; $display("FAIL t5_hdr got=%b exp=00010", flags); end checks++;
        step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        if (flags !== 5'b00000 || bus.out_msg !== 32'h8180_0000) begin errors++; $display("FAIL t5_gap got=%b/%h exp=00000/81800000", flags, bus.out_msg); end checks++;
        step(32'hA, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00010 || bus.out_msg !== 32'hA) begin errors++; $display("FAIL t5_A got=%b/%h exp=00010/a", flags, bus.out_msg); end checks++;
        step(32'hB, 1'b1, 1'b0, 1'b1);
        if (flags !== 5'b00000 || bus.out_msg !== 32'h0 || bus.out_samples !== 32'h0 || bus.error !== 2'b00) begin errors++; $display("FAIL t5_rst got=%b/%h/%h/%b exp=00000/0/0/00", flags, bus.out_msg, bus.out_samples, bus.error); end checks++;
        step(32'hD, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'hD) begin errors++; $display("FAIL t5_D got=%b/%h exp=10000/d", flags, bus.out_samples); end checks++;
    endtask

    task automatic test_abort_bad_dest();
        step(32'h8180_0000, 1'b1, 1'b0, 1'b0);
        step(32'h8118_0000, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00000 || bus.error !== 2'b11) begin errors++; $display("FAIL t7_both got=%b/%b exp=00000/11", flags, bus.error); end checks++;
`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
        if (bus.error_count !== 16'd2) begin errors++; $display("FAIL t7_cnt got=%0d exp=2", bus.error_count); end checks++;
`endif
        step(32'hA, 1'b1, 1'b0, 1'b0);
        step(32'hB, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b00000) begin errors++; $display("FAIL t7_drop got=%b exp=00000", flags); end checks++;
        step(32'h7, 1'b1, 1'b0, 1'b0);
        if (flags !== 5'b10000 || bus.out_samples !== 32'h7) begin errors++; $display("FAIL t7_s7 got=%b/%h exp=10000/7", flags, bus.out_samples); end checks++;
    endtask

    task automatic test_error_clear();
        step(32'h0, 1'b0, 1'b1, 1'b0);
        if (bus.error !== 2'b00) begin errors++; $display("FAIL t6_clr0 got=%b exp=00", bus.error); end checks++;
        for (int i = 1; i <= 3; i++) begin
            step(32'h8018_0000, 1'b1, 1'b0, 1'b0);
            if (bus.error !== 2'b10 || flags !== 5'b00000) begin errors++; $display("FAIL t6_bad%0d got=%b/%b exp=10/00000", i, bus.error, flags); end checks++;
`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
            if (bus.error_count !== 16'(i)) begin errors++; $display("FAIL t6_cnt%0d got=%0d exp=%0d", i, bus.error_count, i); end checks++;
`endif
        end
        step(32'h8018_0000, 1'b1, 1'b1, 1'b0);
        if (bus.error !== 2'b10) begin errors++; $display("FAIL t6_setwins got=%b exp=10", bus.error); end checks++;
`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
        if (bus.error_count !== 16'd1) begin errors++; $display("FAIL t6_cntclr got=%0d exp=1", bus.error_count); end checks++;
`endif
        step(32'h0, 1'b0, 1'b1, 1'b0);
        if (bus.error !== 2'b00) begin errors++; $display("FAIL t6_clr1 got=%b exp=00", bus.error); end checks++;
`ifdef SAMPLE_MSG_DEMUX_ERRCNT_EN
        if (bus.error_count !== 16'd0) begin errors++; $display("FAIL t6_cnt0 got=%0d exp=0", bus.error_count); end checks++;
`endif
    endtask

    initial begin
        test_reset();
        test_routing();
        test_zero_length();
        test_bad_dest();
        test_abort();
        test_gap_and_reset();
        test_abort_bad_dest();
        test_error_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
